hamming_route_stage: RTL and testbench
======================================

# hamming_route_stage

Clocked stage directly downstream of the input processing unit's bit slicer. It joins the 7-bit address stream and the 4-bit payload stream into one transaction. It Hamming-encodes the payload, computes the XY output direction against this router's coordinates, and buffers the result in a small FIFO. The FIFO feeds the router crossbar allocator.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- MY_X, 1, this router's X coordinate (0–7).
- MY_Y, 1, this router's Y coordinate (0–7).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- addr_valid  in  1  address word present.
- addr_ready  out  1  address accepted this cycle.
- addr_in  in  7  [6:4] dst_x, [3:1] dst_y, [0] traffic class.
- data_valid  in  1  payload present.
- data_ready  out  1  payload accepted this cycle.
- data_in  in  4  payload nibble d3..d0.
- out_valid  out  1  head flit valid.
- out_ready  in  1  allocator accepts head.
- out_flit  out  FLIT_W  {addr_in, codeword}.
- out_dir  out  3  0 LOCAL, 1 EAST, 2 WEST, 3 NORTH, 4 SOUTH.
- occupancy  out  $clog2(DEPTH)+1  entries held.

## Operation
- Join:
  - addr_ready = data_valid && !full.
  - data_ready = addr_valid && !full.
  - push only when both valid and !full, so both sides are consumed in the same cycle.
  - A lone valid waits; it is never consumed alone.
- Encode at push with Hamming(7,4):
  - p1=d0^d1^d3, p2=d0^d2^d3, p3=d1^d2^d3.
  - codeword[6:0] = {d3,d2,d1,p3,d0,p2,p1}, so bit i is Hamming position i+1.
- Route at push, XY order, X first:
  - dst_x>MY_X → EAST; dst_x<MY_X → WEST.
  - Otherwise dst_y>MY_Y → NORTH; dst_y<MY_Y → SOUTH.
  - Otherwise LOCAL.
- Each FIFO entry stores flit plus dir. Head entry drives out_flit/out_dir directly from storage, with no combinational path from the inputs.
- Pop when out_valid && out_ready. out_valid = !empty.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count register tracks full/empty.
- Full with a pop in the same cycle: no push that cycle. Ready is evaluated on pre-pop full, which keeps the ready paths free of out_ready.
- Push and pop together when neither full nor empty: occupancy unchanged.
- Empty: out_flit/out_dir hold the last head value; consumers ignore them without out_valid.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - pointers and count 0, out_valid 0, occupancy 0.
  - FIFO storage cleared to 0, so out_flit=0 and out_dir=0.
- Reset mid-transfer discards all entries and does not complete partial handshakes.
- Latency: push on edge N → out_valid high in cycle after N, with flit visible.
- Throughput: one flit per cycle sustained when out_ready held high and FIFO not full.
- Back-pressure: while full, addr_ready/data_ready are low until the edge after a pop.

## Configuration
- HAMMING_SECDED_EN defined:
  - Appends overall parity p0 = XOR of codeword[6:0] as codeword[7].
  - FLIT_W=15: [14:8] address, [7:0] code.
- Undefined:
  - Plain Hamming(7,4).
  - FLIT_W=14: [13:7] address, [6:0] code.

## Structure
- Shared package hamming_route_pkg:
  - FLIT_W, selected by HAMMING_SECDED_EN.
  - dir_t enum (LOCAL..SOUTH).
  - address field bit-position constants.
  - function hamming_encode.
- One sub-module, route_fifo: parameterised DEPTH/WIDTH synchronous FIFO with count; top holds join, encode and route logic.

## Test plan
- Reset with both valids high → readys 0 during reset; out_valid 0, occupancy 0, out_flit 0 after release.
- MY_X=1, MY_Y=1, addr 7'h12, data 4'hB → out_dir 0, codeword 7'h55 (SECDED: 8'h55), out_valid one cycle after push.
- Addr x=3,y=0 → EAST. x=0,y=5 → WEST. x=1,y=5 → NORTH. x=1,y=0 → SOUTH. Data 4'hF → codeword 7'h7F (SECDED 8'hFF).
- addr_valid high with data_valid low for 5 cycles → addr_ready stays 0, no push; data_valid rises → single push.
- out_ready 0, push 4 → occupancy 4, both readys 0. A 5th pair is held off. Pop with a valid pair pending → no push that cycle, push next cycle; pointers wrap, FIFO order preserved.
- out_ready 1, continuous inputs for 20 cycles → 20 flits in order, one per cycle, occupancy ≤1.

Source files
------------

// File: rtl/hamming_route_pkg.sv
// Shared types and helpers for the Hamming route stage.
// HAMMING_SECDED_EN adds an overall parity bit to the codeword.
package hamming_route_pkg;

`ifdef HAMMING_SECDED_EN
  localparam int FLIT_W = 15;
`else
  localparam int FLIT_W = 14;
`endif

  localparam int ADDR_W = 7;
  localparam int CODE_W = FLIT_W - ADDR_W;
  localparam int DIR_W  = 3;

  localparam int DX_HI  = 6;
  localparam int DX_LO  = 4;
  localparam int DY_HI  = 3;
  localparam int DY_LO  = 1;
  localparam int TC_BIT = 0;

  typedef enum logic [DIR_W-1:0] {
    DIR_LOCAL = 3'd0,
    DIR_EAST  = 3'd1,
    DIR_WEST  = 3'd2,
    DIR_NORTH = 3'd3,
    DIR_SOUTH = 3'd4
  } dir_t;

  // Bit i of the 7-bit code is Hamming position i+1.
  function automatic logic [CODE_W-1:0] hamming_encode(
    input logic [3:0] d
  );
    logic p1, p2, p3;
    logic [6:0] cw;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p3 = d[1] ^ d[2] ^ d[3];
    cw = {d[3], d[2], d[1], p3, d[0], p2, p1};
`ifdef HAMMING_SECDED_EN
    return {^cw, cw};
`else
    return cw;
`endif
  endfunction

endpackage

// File: rtl/hamming_route_stage_route_fifo.sv
// Synchronous FIFO with occupancy count; head driven from storage.
// Configuration: HAMMING_SECDED_EN only affects WIDTH via the top.
module route_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [AW-1:0]    head_idx;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  // When empty, show the slot just popped so the last head holds.
  assign head_idx = empty_o ? rptr_q - AW'(1) : rptr_q;
  assign rdata_o  = mem_q[head_idx];

endmodule

// File: rtl/hamming_route_stage.sv
// Joins address and payload, Hamming-encodes, XY-routes, buffers.
// Configuration: HAMMING_SECDED_EN selects 8-bit SECDED code.
module hamming_route_stage
  import hamming_route_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int MY_X  = 1,
  parameter int MY_Y  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   addr_valid,
  output logic                   addr_ready,
  input  logic [ADDR_W-1:0]      addr_in,
  input  logic                   data_valid,
  output logic                   data_ready,
  input  logic [3:0]             data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FLIT_W-1:0]      out_flit,
  output logic [DIR_W-1:0]       out_dir,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam logic [2:0] MX = MY_X[2:0];
  localparam logic [2:0] MY = MY_Y[2:0];

  logic                    full, empty;
  logic                    in_ok, push, pop;
  logic [2:0]              dst_x, dst_y;
  dir_t                    dir;
  logic [CODE_W-1:0]       code;
  logic [FLIT_W+DIR_W-1:0] wdata, rdata;

  // Readies use pre-pop full so they never depend on out_ready.
  assign in_ok      = rst_n && !full;
  assign addr_ready = data_valid && in_ok;
  assign data_ready = addr_valid && in_ok;
  assign push       = addr_valid && data_valid && in_ok;

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  assign dst_x = addr_in[DX_HI:DX_LO];
  assign dst_y = addr_in[DY_HI:DY_LO];

  always_comb begin
    dir = DIR_LOCAL;
    unique case (1'b1)
      (dst_x > MX):                 dir = DIR_EAST;
      (dst_x < MX):                 dir = DIR_WEST;
      (dst_x == MX && dst_y > MY):  dir = DIR_NORTH;
      (dst_x == MX && dst_y < MY):  dir = DIR_SOUTH;
      default:                      dir = DIR_LOCAL;
    endcase
  end

  assign code  = hamming_encode(data_in);
  assign wdata = {addr_in, code, dir};

  route_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FLIT_W + DIR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .count_o (occupancy)
  );

  assign out_flit = rdata[FLIT_W+DIR_W-1:DIR_W];
  assign out_dir  = rdata[DIR_W-1:0];

endmodule

// File: tb/tb_hamming_route_stage.sv
// Directed table-driven bench for hamming_route_stage.
// Expected codes are written for SECDED; HAMMING_SECDED_EN selects width.
module tb_hamming_route_stage;
  import hamming_route_pkg::*;

  localparam int CW = CODE_W;

  logic clk = 1'b0;
  logic rst_n;
  logic addr_valid, addr_ready;
  logic [6:0] addr_in;
  logic data_valid, data_ready;
  logic [3:0] data_in;
  logic out_valid, out_ready;
  logic [FLIT_W-1:0] out_flit;
  logic [2:0] out_dir;
  logic [2:0] occupancy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hamming_route_stage #(.DEPTH(4), .MY_X(1), .MY_Y(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr_in    (addr_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_in    (data_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_flit   (out_flit),
    .out_dir    (out_dir),
    .occupancy  (occupancy)
  );

  typedef struct {
    logic [6:0] addr;
    logic [3:0] data;
    logic [2:0] dir;
    logic [7:0] code;
  } vec_t;

  vec_t tv [8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] cw_of(input logic [7:0] c);
    return c[CW-1:0];
  endfunction

  // Independent reference for streaming data: SECDED form of the spec code.
  function automatic logic [7:0] ham(input logic [3:0] d);
    logic [6:0] c;
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[2] = d[0];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    return {^c, c};
  endfunction

  logic [7:0] fcodes [4];

  initial begin
    tv[0] = '{7'h12, 4'hB, 3'd0, 8'h55};
    tv[1] = '{7'h30, 4'hF, 3'd1, 8'hFF};
    tv[2] = '{7'h0B, 4'h0, 3'd2, 8'h00};
    tv[3] = '{7'h1A, 4'h1, 3'd3, 8'h87};
    tv[4] = '{7'h11, 4'h2, 3'd4, 8'h99};
    tv[5] = '{7'h7E, 4'h8, 3'd1, 8'h4B};
    tv[6] = '{7'h13, 4'h4, 3'd0, 8'hAA};
    tv[7] = '{7'h02, 4'h7, 3'd2, 8'hB4};
    fcodes[0] = 8'h99;
    fcodes[1] = 8'h1E;
    fcodes[2] = 8'hAA;
    fcodes[3] = 8'h2D;

    rst_n = 1'b0;
    addr_valid = 1'b1;
    data_valid = 1'b1;
    addr_in = 7'h12;
    data_in = 4'hB;
    out_ready = 1'b0;
    #3;
    chk("rst_addr_ready", 32'(addr_ready), 32'd0);
    chk("rst_data_ready", 32'(data_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr_ready2", 32'(addr_ready), 32'd0);
    addr_valid = 1'b0;
    data_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_out_valid", 32'(out_valid), 32'd0);
    chk("rel_occupancy", 32'(occupancy), 32'd0);
    chk("rel_out_flit", 32'(out_flit), 32'd0);
    chk("rel_out_dir", 32'(out_dir), 32'd0);

    for (int i = 0; i < 8; i++) begin
      addr_in = tv[i].addr;
      data_in = tv[i].data;
      addr_valid = 1'b1;
      data_valid = 1'b1;
      #1;
      chk("vec_addr_ready", 32'(addr_ready), 32'd1);
      tick();
      addr_valid = 1'b0;
      data_valid = 1'b0;
      chk("vec_out_valid", 32'(out_valid), 32'd1);
      chk("vec_flit", 32'(out_flit), 32'({tv[i].addr, cw_of(tv[i].code)}));
      chk("vec_dir", 32'(out_dir), 32'(tv[i].dir));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("vec_drained", 32'(occupancy), 32'd0);
    end
    chk("empty_hold_flit", 32'(out_flit),
        32'({tv[7].addr, cw_of(tv[7].code)}));
    chk("empty_hold_valid", 32'(out_valid), 32'd0);

    addr_in = 7'h12;
    data_in = 4'h3;
    addr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("lone_addr_ready", 32'(addr_ready), 32'd0);
      tick();
      chk("lone_no_push", 32'(occupancy), 32'd0);
    end
    data_valid = 1'b1;
    #1;
    chk("join_addr_ready", 32'(addr_ready), 32'd1);
    tick();
    addr_valid = 1'b0;
    data_valid = 1'b0;
    chk("join_single_push", 32'(occupancy), 32'd1);
    chk("join_code", 32'(out_flit[CW-1:0]), 32'(cw_of(8'h1E)));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("join_drained", 32'(occupancy), 32'd0);

    addr_valid = 1'b1;
    data_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      data_in = 4'(k);
      tick();
    end
    data_in = 4'h5;
    chk("full_occ", 32'(occupancy), 32'd4);
    chk("full_addr_ready", 32'(addr_ready), 32'd0);
    chk("full_data_ready", 32'(data_ready), 32'd0);
    tick();
    chk("full_held_off", 32'(occupancy), 32'd4);
    out_ready = 1'b1;
    #1;
    chk("full_pop_ready", 32'(addr_ready), 32'd0);
    tick();
    out_ready = 1'b0;
    chk("pop_no_push", 32'(occupancy), 32'd3);
    chk("after_pop_ready", 32'(addr_ready), 32'd1);
    tick();
    addr_valid = 1'b0;
    data_valid = 1'b0;
    chk("refill_occ", 32'(occupancy), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("wrap_order", 32'(out_flit[CW-1:0]), 32'(cw_of(fcodes[k])));
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    chk("wrap_drained", 32'(occupancy), 32'd0);

    out_ready = 1'b1;
    addr_in = 7'h30;
    addr_valid = 1'b1;
    data_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data_in = 4'(i);
      tick();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_occ", 32'(occupancy), 32'd1);
      chk("stream_code", 32'(out_flit[CW-1:0]), 32'(cw_of(ham(4'(i)))));
      chk("stream_dir", 32'(out_dir), 32'd1);
    end
    addr_valid = 1'b0;
    data_valid = 1'b0;
    tick();
    chk("stream_end_occ", 32'(occupancy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
